// File: rtl/sequence_display.sv
// -----------------------------------------------------------------------------
// sequence_display
//
// Playback side of the memory-game sequence path. A start request fetches the
// stored 20-bit sequence word from the sequence RAM, then shows the first LVL
// nibbles one at a time. Each digit has a timed on-period followed by a timed
// blank gap. After the last gap a one-cycle display_done pulse tells the
// sequence checker that it may start accepting button presses.
//
// Parameters
//   ON_CYCLES   : clock cycles each digit is shown (>= 1)
//   OFF_CYCLES  : clock cycles of blank gap after each digit (>= 1)
//   TW          : timer width, must hold max(ON_CYCLES, OFF_CYCLES)-1
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   playback request, sampled only while idle
//   LVL          in   number of digits to show (clamped to 5), latched on start
//   S_in         in   RAM read data; digit 1 = [19:16] ... digit 5 = [3:0]
//   RAM_r        out  one-cycle RAM read strobe
//   RAM_addr     out  RAM address, always 0 (single sequence word)
//   disp_num     out  digit value to display, 0 when blank
//   disp_en      out  high while a digit is shown
//   digit_idx    out  1-based index of current/last digit, 0 when idle
//   busy         out  high from accepted start through the done cycle
//   display_done out  one-cycle pulse when playback has finished
// -----------------------------------------------------------------------------
module sequence_display #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int TW         = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  LVL,
    input  logic [19:0] S_in,
    output logic        RAM_r,
    output logic [4:0]  RAM_addr,
    output logic [3:0]  disp_num,
    output logic        disp_en,
    output logic [2:0]  digit_idx,
    output logic        busy,
    output logic        display_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CYC1  = 3'd2;
    localparam logic [2:0] S_CYC2  = 3'd3;
    localparam logic [2:0] S_CATCH = 3'd4;
    localparam logic [2:0] S_SHOW  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    logic [2:0]    state_q,     state_d;
    logic [2:0]    lvl_q,       lvl_d;
    logic [19:0]   seq_q,       seq_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          ram_r_q,     ram_r_d;
    logic [4:0]    ram_addr_q,  ram_addr_d;
    logic [3:0]    disp_num_q,  disp_num_d;
    logic          disp_en_q,   disp_en_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    // Nibble for a 1-based digit index; digit 1 is the most significant.
    function automatic logic [3:0] nibble_at(input logic [19:0] w,
                                             input logic [2:0]  idx);
        logic [3:0] n;
        case (idx)
            3'd1:    n = w[19:16];
            3'd2:    n = w[15:12];
            3'd3:    n = w[11:8];
            3'd4:    n = w[7:4];
            3'd5:    n = w[3:0];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        seq_d       = seq_q;
        timer_d     = timer_q;
        ram_r_d     = ram_r_q;
        ram_addr_d  = '0;
        disp_num_d  = disp_num_q;
        disp_en_d   = disp_en_q;
        digit_idx_d = digit_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            S_IDLE: begin
                digit_idx_d = '0;
                if (start) begin
                    lvl_d   = (LVL > 3'd5) ? 3'd5 : LVL;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                ram_addr_d = '0;
                ram_r_d    = 1'b1;
                state_d    = S_CYC1;
            end

            S_CYC1: begin
                ram_r_d = 1'b0;
                state_d = S_CYC2;
            end

            // Second full cycle of RAM access time after the strobe.
            S_CYC2: begin
                state_d = S_CATCH;
            end

            S_CATCH: begin
                seq_d   = S_in;
                timer_d = '0;
                if (lvl_q == 3'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    digit_idx_d = 3'd1;
                    disp_num_d  = S_in[19:16];
                    disp_en_d   = 1'b1;
                    state_d     = S_SHOW;
                end
            end

            S_SHOW: begin
                if (timer_q == ON_LAST) begin
                    disp_en_d  = 1'b0;
                    disp_num_d = '0;
                    timer_d    = '0;
                    state_d    = S_GAP;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            S_GAP: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (digit_idx_q == lvl_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        digit_idx_d = digit_idx_q + 3'd1;
                        disp_num_d  = nibble_at(seq_q, digit_idx_q + 3'd1);
                        disp_en_d   = 1'b1;
                        state_d     = S_SHOW;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            S_DONE: begin
                done_d     = 1'b0;
                busy_d     = 1'b0;
                disp_num_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                ram_r_d     = 1'b0;
                disp_num_d  = '0;
                disp_en_d   = 1'b0;
                digit_idx_d = '0;
                busy_d      = 1'b0;
                done_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lvl_q       <= '0;
            seq_q       <= '0;
            timer_q     <= '0;
            ram_r_q     <= 1'b0;
            ram_addr_q  <= '0;
            disp_num_q  <= '0;
            disp_en_q   <= 1'b0;
            digit_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            seq_q       <= seq_d;
            timer_q     <= timer_d;
            ram_r_q     <= ram_r_d;
            ram_addr_q  <= ram_addr_d;
            disp_num_q  <= disp_num_d;
            disp_en_q   <= disp_en_d;
            digit_idx_q <= digit_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign RAM_r        = ram_r_q;
    assign RAM_addr     = ram_addr_q;
    assign disp_num     = disp_num_q;
    assign disp_en      = disp_en_q;
    assign digit_idx    = digit_idx_q;
    assign busy         = busy_q;
    assign display_done = done_q;

endmodule

// File: tb/tb_sequence_display.sv
// -----------------------------------------------------------------------------
// tb_sequence_display
//
// Bench for sequence_display with ON_CYCLES=4, OFF_CYCLES=2. A cycle-level
// model derives every output from the number of edges since the accepted start
// (latency, period and clamped level arithmetic) and is compared against the
// DUT on every falling edge. Directed playbacks add literal expectations for
// the reference word 20'h3A51C, followed by a randomized stress phase.
// -----------------------------------------------------------------------------
module tb_sequence_display;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  LVL = 3'd0;
    logic [19:0] S_in = 20'h3A51C;
    logic        RAM_r;
    logic [4:0]  RAM_addr;
    logic [3:0]  disp_num;
    logic        disp_en;
    logic [2:0]  digit_idx;
    logic        busy;
    logic        display_done;

    sequence_display #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .TW         (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .LVL          (LVL),
        .S_in         (S_in),
        .RAM_r        (RAM_r),
        .RAM_addr     (RAM_addr),
        .disp_num     (disp_num),
        .disp_en      (disp_en),
        .digit_idx    (digit_idx),
        .busy         (busy),
        .display_done (display_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_act = 1'b0;
    int          m_n   = 0;
    int          m_lvl = 0;
    logic [19:0] m_seq = '0;
    int          e_ram, e_num, e_en, e_idx, e_busy, e_done;

    function automatic logic [3:0] nib(input logic [19:0] w, input int k);
        logic [19:0] s;
        s = w << (4 * (k - 1));
        return s[19:16];
    endfunction

    always @(posedge clk or negedge rst) begin
        int d, k;
        if (!rst) begin
            m_act = 1'b0; m_n = 0; m_lvl = 0; m_seq = '0;
            e_ram = 0; e_num = 0; e_en = 0; e_idx = 0; e_busy = 0; e_done = 0;
        end else begin
            if (!m_act) begin
                if (start) begin
                    m_act = 1'b1;
                    m_n   = 0;
                    m_lvl = (LVL > 5) ? 5 : int'(LVL);
                end
            end else begin
                m_n++;
            end
            if (m_act && m_n == 4) m_seq = S_in;
            e_ram = 0; e_num = 0; e_en = 0; e_idx = 0; e_busy = 0; e_done = 0;
            if (m_act) begin
                d      = 4 + m_lvl * P;
                e_busy = (m_n <= d) ? 1 : 0;
                e_ram  = (m_n == 1) ? 1 : 0;
                e_done = (m_n == d) ? 1 : 0;
                if (m_n >= 4 && m_lvl > 0) begin
                    k = (m_n - 4) / P + 1;
                    if (k > m_lvl) k = m_lvl;
                    e_idx = k;
                    if (m_n < d && ((m_n - 4) % P) < ON) begin
                        e_en  = 1;
                        e_num = int'(nib(m_seq, k));
                    end
                end
                if (m_n == d + 1) m_act = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("RAM_r",        int'(RAM_r),        e_ram);
        chk("RAM_addr",     int'(RAM_addr),     0);
        chk("disp_num",     int'(disp_num),     e_num);
        chk("disp_en",      int'(disp_en),      e_en);
        chk("digit_idx",    int'(digit_idx),    e_idx);
        chk("busy",         int'(busy),         e_busy);
        chk("display_done", int'(display_done), e_done);
    end

    // ---------------- directed playback capture ----------------
    logic [3:0] shown[$];
    int done_at, busy_fall, ram_at, ram_pulses, done_pulses, en_cycles;

    task automatic run_play(input logic [2:0] lvl, input bit disturb, input int span);
        logic prev_en;
        shown.delete();
        done_at = -1; busy_fall = -1; ram_at = -1;
        ram_pulses = 0; done_pulses = 0; en_cycles = 0; prev_en = 1'b0;
        @(posedge clk); #1 start = 1'b1; LVL = lvl;
        @(posedge clk); #1 start = 1'b0;          // this edge is edge 0
        for (int n = 1; n <= span; n++) begin
            @(posedge clk); #1;
            if (disturb && n == 4) begin start = 1'b1; LVL = 3'd1; S_in = '0; end
            if (disturb && n == 5) start = 1'b0;
            if (RAM_r) begin ram_pulses++; if (ram_at < 0) ram_at = n; end
            if (display_done) begin done_pulses++; if (done_at < 0) done_at = n; end
            if (done_at >= 0 && busy_fall < 0 && !busy) busy_fall = n;
            if (disp_en) begin
                en_cycles++;
                if (!prev_en) shown.push_back(disp_num);
            end
            prev_en = disp_en;
        end
    endtask

    task automatic chk_digits(input string nm, input logic [19:0] w, input int cnt);
        chk({nm, "_count"}, shown.size(), cnt);
        for (int i = 0; i < cnt && i < shown.size(); i++)
            chk($sformatf("%s_digit%0d", nm, i + 1), int'(shown[i]), int'(nib(w, i + 1)));
    endtask

    initial begin
        int waited, stray;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // LVL=3 with a start/LVL/S_in disturbance after edge 4
        run_play(3'd3, 1'b1, 30);
        chk("l3_ram_at", ram_at, 1);
        chk("l3_ram_pulses", ram_pulses, 1);
        chk("l3_done_at", done_at, 22);
        chk("l3_done_pulses", done_pulses, 1);
        chk("l3_busy_fall", busy_fall, 23);
        chk("l3_en_cycles", en_cycles, 12);
        chk("l3_first", int'(shown.size() > 0 ? shown[0] : 4'hF), 3);
        chk_digits("l3", 20'h3A51C, 3);
        S_in = 20'h3A51C;

        run_play(3'd5, 1'b0, 38);
        chk("l5_done_at", done_at, 34);
        chk("l5_en_cycles", en_cycles, 20);
        chk("l5_last", int'(shown.size() == 5 ? shown[4] : 4'hF), 4'hC);
        chk_digits("l5", 20'h3A51C, 5);

        run_play(3'd7, 1'b0, 38);
        chk("l7_done_at", done_at, 34);
        chk("l7_done_pulses", done_pulses, 1);
        chk_digits("l7", 20'h3A51C, 5);

        run_play(3'd0, 1'b0, 8);
        chk("l0_done_at", done_at, 4);
        chk("l0_busy_fall", busy_fall, 5);
        chk("l0_en_cycles", en_cycles, 0);

        // Reset asserted between edges during a SHOW phase
        @(posedge clk); #1 start = 1'b1; LVL = 3'd3;
        @(posedge clk); #1 start = 1'b0;
        waited = 0;
        while (!disp_en && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        chk("rst_reached_show", int'(disp_en), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_RAM_r", int'(RAM_r), 0);
        chk("rst_disp_num", int'(disp_num), 0);
        chk("rst_disp_en", int'(disp_en), 0);
        chk("rst_digit_idx", int'(digit_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(display_done), 0);
        chk("rst_RAM_addr", int'(RAM_addr), 0);
        @(posedge clk); #1 rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (display_done) stray++;
        end
        chk("rst_no_done", stray, 0);
        run_play(3'd1, 1'b0, 14);
        chk("post_rst_done_at", done_at, 10);
        chk_digits("post_rst", 20'h3A51C, 1);

        // Randomized stress: random start pulses, levels and RAM words
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 9) == 0);
            LVL   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) S_in = 20'($urandom());
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
